mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single core-side port of the write-through line cache between the core's instruction and data ports.
//  Accepts one request at a time (OBI-style req/gnt), issues it to the cache as a 1-cycle req pulse, then routes
//  cache_rvalid_i/cache_rdata_i back to the owning requester. A watchdog recovers from a cache that never responds.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before error completion; legal range >=2
//  ROUND_ROBIN     1   1: alternate on contention; 0: data port has fixed priority
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-high reset
//  instr_req_i     in   1   instruction fetch request; held until instr_gnt_o
//  instr_addr_i    in   32  fetch address
//  instr_gnt_o     out  1   request accepted (combinational, IDLE only)
//  instr_rvalid_o  out  1   1-cycle response strobe
//  instr_rdata_o   out  32  fetch data, valid with instr_rvalid_o
//  instr_err_o     out  1   response is a timeout error, valid with instr_rvalid_o
//  data_req_i      in   1   load/store request; held until data_gnt_o
//  data_addr_i     in   32  load/store address
//  data_wdata_i    in   32  store data
//  data_we_i       in   1   1=store
//  data_be_i       in   4   store byte enables
//  data_gnt_o      out  1   request accepted
//  data_rvalid_o   out  1   1-cycle response strobe
//  data_rdata_o    out  32  load data
//  data_err_o      out  1   timeout error
//  cache_req_o     out  1   request to cache (registered)
//  cache_addr_o    out  32  latched address
//  cache_wdata_o   out  32  latched wdata (0 for fetch)
//  cache_we_o      out  1   latched we (0 for fetch)
//  cache_be_o      out  4   latched be (4'b1111 for fetch)
//  cache_gnt_i     in   1   cache accepted cache_req_o
//  cache_rvalid_i  in   1   cache response strobe
//  cache_rdata_i   in   32  cache read data
//  busy_o          out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched addr/wdata/we/be=0; owner=DATA; last_grant=INSTR; wd_cnt=0.
//  States: IDLE, ISSUE, WAIT, FLUSH (2-bit encoding).
//  IDLE: if any req, pick winner, assert winner gnt combinationally the same cycle (the other gnt stays 0).
//    Latch winner's addr/wdata/we/be and owner. Next state ISSUE. Requests that are not yet granted may drop.
//    Contention with ROUND_ROBIN=1: grant the port != last_grant. Contention with ROUND_ROBIN=0: DATA wins.
//    last_grant updates on every grant. Any cache_rvalid_i seen in IDLE is ignored.
//  ISSUE: cache_req_o=1 with the latched fields; stay until cache_gnt_i=1, then WAIT with wd_cnt=0.
//    In the steady state the cache holds gnt high, so ISSUE lasts exactly 1 cycle.
//  WAIT: wd_cnt increments each cycle. On cache_rvalid_i: owner rvalid_o=1, rdata_o=cache_rdata_i (combinational
//    pass-through, same cycle), err_o=0; next IDLE.
//    Otherwise, if wd_cnt==TIMEOUT_CYCLES-1: owner rvalid_o=1, rdata_o=0, err_o=1; next FLUSH, wd_cnt=0.
//    If rvalid and expiry coincide, rvalid wins (normal completion).
//  FLUSH: no grants. Wait for a stale cache_rvalid_i, which is dropped and not routed, or a second expiry; then IDLE.
//  Non-owner rvalid_o/err_o are always 0. rdata_o of a port is 0 except in its rvalid cycle.
//  No gnt is given outside IDLE, so at most one transaction is outstanding. A new grant is possible the cycle
//    after an rvalid, and the cache is back in its idle state by the ISSUE cycle.
//  Best case, grant to response: 1 (ISSUE) + cache latency; read hit = 4 cycles after grant.
//  wd_cnt width: $clog2(TIMEOUT_CYCLES+1); it never wraps because it clears on leaving WAIT/FLUSH.
//  Reset during ISSUE/WAIT/FLUSH: the transaction is abandoned with no rvalid emitted; the cache is reset alongside.
// TESTING
//  1 Data read: data_req, addr=0x100, gnt in cycle 0 -> cache_req_o 1 cycle, addr=0x100, we=0;
//    cache_rvalid, rdata=0xDEADBEEF -> data_rvalid_o=1, data_rdata_o=0xDEADBEEF; instr_rvalid_o stays 0.
//  2 Both req held 4 transactions with ROUND_ROBIN=1 -> grant order DATA, INSTR, DATA, INSTR.
//    Same stimulus with ROUND_ROBIN=0 -> DATA x4 before the first INSTR grant.
//  3 Store: data addr=0x40, wdata=0x11223344, we=1, be=4'b0011 -> cache_we_o=1, cache_be_o=4'b0011,
//    cache_wdata_o=0x11223344. Fetch -> cache_be_o=4'b1111, cache_we_o=0.
//  4 Cache never returns rvalid, TIMEOUT_CYCLES=8 -> owner rvalid+err exactly 8 cycles after entering WAIT,
//    rdata=0, busy_o stays 1 in FLUSH.
//  5 In FLUSH, a late cache_rvalid_i with rdata=0x5 is not routed -> next IDLE; the next grant then completes normally.
//  6 Reset asserted mid-WAIT -> the same cycle all outputs are 0 and state=IDLE; rvalid arriving after release is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core instruction/data ports and the cache-side port.
// The slave modport is the arbiter's view; master is the core/cache environment's view.
interface mem_port_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        cache_req_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_wdata_o;
  logic        cache_we_o;
  logic [3:0]  cache_be_o;
  logic        cache_gnt_i;
  logic        cache_rvalid_i;
  logic [31:0] cache_rdata_i;

  logic        busy_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_addr_i, data_wdata_i, data_we_i, data_be_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output cache_req_o, cache_addr_o, cache_wdata_o, cache_we_o, cache_be_o,
    input  cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    output busy_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_addr_i, data_wdata_i, data_we_i, data_be_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  cache_req_o, cache_addr_o, cache_wdata_o, cache_we_o, cache_be_o,
    output cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single cache port between the core's instruction and data ports, one
// transaction at a time, with a watchdog that completes a hung request with an error.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          ROUND_ROBIN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  state_e          state_q, state_d;
  port_e           owner_q, owner_d;
  port_e           last_grant_q, last_grant_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  port_e winner;
  logic  instr_gnt, data_gnt;
  logic  resp_valid, resp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_DATA;
      last_grant_q <= PORT_INSTR;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    be_d         = be_q;
    wd_cnt_d     = wd_cnt_q;
    winner       = PORT_DATA;
    instr_gnt    = 1'b0;
    data_gnt     = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_req_i && bus.data_req_i) begin
          winner = (ROUND_ROBIN && (last_grant_q == PORT_DATA)) ? PORT_INSTR : PORT_DATA;
        end else if (bus.instr_req_i) begin
          winner = PORT_INSTR;
        end
        // Grants are combinational, so mask them while reset holds the state register.
        if (!reset && (bus.instr_req_i || bus.data_req_i)) begin
          instr_gnt    = (winner == PORT_INSTR);
          data_gnt     = (winner == PORT_DATA);
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ST_ISSUE;
          if (winner == PORT_DATA) begin
            addr_d  = bus.data_addr_i;
            wdata_d = bus.data_wdata_i;
            we_d    = bus.data_we_i;
            be_d    = bus.data_be_i;
          end else begin
            addr_d  = bus.instr_addr_i;
            wdata_d = '0;
            we_d    = 1'b0;
            be_d    = '1;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.cache_gnt_i) begin
          state_d  = ST_WAIT;
          wd_cnt_d = '0;
        end
      end

      ST_WAIT: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (bus.cache_rvalid_i) begin
          resp_valid = 1'b1;
          state_d    = ST_IDLE;
          wd_cnt_d   = '0;
        end else if (wd_cnt_q == WD_LAST) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = ST_FLUSH;
          wd_cnt_d   = '0;
        end
      end

      ST_FLUSH: begin
        // A late response belongs to the abandoned request and is swallowed here.
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (bus.cache_rvalid_i || (wd_cnt_q == WD_LAST)) begin
          state_d  = ST_IDLE;
          wd_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.instr_gnt_o    = instr_gnt;
  assign bus.data_gnt_o     = data_gnt;

  assign bus.instr_rvalid_o = resp_valid && (owner_q == PORT_INSTR);
  assign bus.instr_err_o    = resp_err && (owner_q == PORT_INSTR);
  assign bus.instr_rdata_o  = (resp_valid && !resp_err && (owner_q == PORT_INSTR))
                              ? bus.cache_rdata_i : '0;

  assign bus.data_rvalid_o  = resp_valid && (owner_q == PORT_DATA);
  assign bus.data_err_o     = resp_err && (owner_q == PORT_DATA);
  assign bus.data_rdata_o   = (resp_valid && !resp_err && (owner_q == PORT_DATA))
                              ? bus.cache_rdata_i : '0;

  assign bus.cache_req_o    = (state_q == ST_ISSUE);
  assign bus.cache_addr_o   = addr_q;
  assign bus.cache_wdata_o  = wdata_q;
  assign bus.cache_we_o     = we_q;
  assign bus.cache_be_o     = be_q;

  assign bus.busy_o         = (state_q != ST_IDLE);

endmodule
